apb_follower_regbank: RTL

//  APB completer: a word-addressed register bank with programmable wait states.

---
 rtl/apb_follower_regbank_if.sv | 49 ++++
 rtl/apb_follower_regbank.sv | 119 +++++++++++
 2 files changed

// File: rtl/apb_follower_regbank_if.sv
// APB completer-side bus bundle for apb_follower_regbank.
//   master : the APB leader side (drives select/enable/address/data).
//   slave  : the completer side (returns PREADY/PRDATA/PSLVERR).
// Signals:
//   PSEL     completer select (one bit of the leader's PSEL vector)
//   PENABLE  access phase
//   PWRITE   1=write, 0=read
//   PADDR    word address, MSB is the completer-select bit
//   PWDATA   write data
//   PREADY   transfer complete
//   PRDATA   read data, valid only while PREADY=1 on a read
//   PSLVERR  error, valid only while PREADY=1
interface apb_follower_regbank_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
    input  PREADY,
    input  PRDATA,
    input  PSLVERR
  );

  modport slave (
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    output PREADY,
    output PRDATA,
    output PSLVERR
  );

endinterface

// File: rtl/apb_follower_regbank.sv
// APB completer: word-addressed register bank with a fixed number of
// access-phase wait states before PREADY.
// Ports:
//   PCLK     clock, rising edge
//   PRESETN  asynchronous, active-low reset; aborts any transfer in flight
//   apb      completer side of apb_follower_regbank_if
//            (PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PREADY/PRDATA/PSLVERR out)
// Address decode: the low $clog2(DEPTH) bits select the register, any set bit
// between that field and the MSB flags the transfer out of range, and the MSB
// (leader's completer select) is ignored.
module apb_follower_regbank #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   PCLK,
  input  logic                   PRESETN,
  apb_follower_regbank_if.slave  apb
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LOW_W = ADDR_WIDTH - 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      lat_idx;
  logic                  lat_write;
  logic                  lat_oor;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic                  oor_c;
  logic                  complete_c;
  logic                  wr_en_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  unused_paddr_msb;

  // Leader's completer-select bit; decoded upstream.
  assign unused_paddr_msb = apb.PADDR[ADDR_WIDTH-1];

  // Out of range when any address bit above the index field (below the MSB) is set.
  assign oor_c = ((apb.PADDR[LOW_W-1:0] >> IDX_W) != '0);

  // Completion: wait states exhausted and the leader is in its access phase.
  assign complete_c = (state == ACCESS) && (cnt == '0) && apb.PSEL && apb.PENABLE;
  assign wr_en_c    = complete_c && lat_write && !lat_oor;

  // Read data only on an in-range read completion; zero otherwise.
  always_comb begin
    rdata_c = '0;
    if (complete_c && !lat_write && !lat_oor) begin
      rdata_c = regs[lat_idx];
    end
  end

  assign apb.PREADY  = complete_c;
  assign apb.PRDATA  = rdata_c;
  assign apb.PSLVERR = complete_c && lat_oor;

  // Transfer sequencing: latch request at setup, count wait states, finish or abort.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_oor   <= 1'b0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            state     <= ACCESS;
            cnt       <= CNT_W'(WAIT_CYCLES);
            lat_idx   <= apb.PADDR[IDX_W-1:0];
            lat_write <= apb.PWRITE;
            lat_oor   <= oor_c;
            lat_wdata <= apb.PWDATA;
          end
        end
        ACCESS: begin
          if (!apb.PSEL) begin
            // Leader dropped select: abandon without committing anything.
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (apb.PENABLE) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Register storage; written only on an in-range write completion.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs[lat_idx] <= lat_wdata;
    end
  end

endmodule
